// File: rtl/spectrum_pkg.sv
// Shared types and helpers for the spectrum threshold detector.
package spectrum_pkg;

   localparam int unsigned FFT_MIN    = 16;
   localparam int unsigned FFT_MAX    = 32768;
   localparam int unsigned HIT_IDX_W  = 16;
   localparam int unsigned HIT_DATA_W = 16;

   typedef enum logic [0:0] {
      StIdle,
      StRun
   } state_e;

   typedef struct packed {
      logic [HIT_IDX_W-1:0]  idx;
      logic [HIT_DATA_W-1:0] power;
   } hit_t;

   // Power of two within FFT_MIN..FFT_MAX.
   function automatic logic is_valid_fft_size(input logic [15:0] n);
      return (32'(n) >= FFT_MIN) && (32'(n) <= FFT_MAX) && ((n & (n - 16'd1)) == 16'd0);
   endfunction

endpackage

// File: rtl/spectrum_detector_if.sv
// Bin input stream and hit output stream of the spectrum detector.
interface spectrum_detector_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned IDX_W  = 16
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_power;
   logic              s_last;
   logic              m_valid;
   logic              m_ready;
   logic [IDX_W-1:0]  m_idx;
   logic [DATA_W-1:0] m_power;

   modport master (
      output s_valid, s_power, s_last, m_ready,
      input  s_ready, m_valid, m_idx, m_power
   );

   modport slave (
      input  s_valid, s_power, s_last, m_ready,
      output s_ready, m_valid, m_idx, m_power
   );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO; head entry is presented straight from the storage flops.
module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   // Full is judged on the registered count, so a same-cycle pop never makes room.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/spectrum_detector.sv
// Per-bin threshold detector with hit FIFO, per-frame occupancy summary and sticky errors.
module spectrum_detector
   import spectrum_pkg::*;
#(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned IDX_W     = 16,
   parameter int unsigned HIT_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [15:0]       fft_size,
   input  logic [DATA_W-1:0] thresh,
   input  logic              err_clr,
   spectrum_detector_if.slave bus,
   output logic              frame_done,
   output logic [IDX_W-1:0]  frame_cnt,
   output logic [IDX_W-1:0]  occ_count,
   output logic              cfg_err,
   output logic              sync_err,
   output logic              ovf
);
   localparam int unsigned HIT_W = IDX_W + DATA_W;

   state_e            state_q;
   logic [15:0]       n_q;
   logic [DATA_W-1:0] thresh_q;
   logic [IDX_W-1:0]  bin_q, occ_acc_q, occ_next;
   logic              accept, is_hit, last_bin, frame_end;
   logic              cfg_ok, cfg_ev, sync_ev, ovf_ev;
   logic              fifo_full, fifo_empty, fifo_pop;
   logic [HIT_W-1:0]  fifo_dout;

   assign bus.s_ready = (state_q == StRun);
   assign accept      = bus.s_valid && bus.s_ready;
   assign is_hit      = accept && (bus.s_power > thresh_q);
   assign last_bin    = (bin_q == IDX_W'(n_q - 16'd1));
   assign frame_end   = accept && last_bin;
   assign cfg_ok      = is_valid_fft_size(fft_size);
   assign cfg_ev      = enable && !cfg_ok && ((state_q == StIdle) || frame_end);
   assign sync_ev     = accept && (bus.s_last != last_bin);
   assign ovf_ev      = is_hit && fifo_full;
   assign occ_next    = (is_hit && (occ_acc_q != '1)) ? occ_acc_q + IDX_W'(1) : occ_acc_q;

   assign fifo_pop    = bus.m_valid && bus.m_ready;
   assign bus.m_valid = !fifo_empty;
   assign {bus.m_idx, bus.m_power} = fifo_dout;

   sync_fifo #(
      .WIDTH (HIT_W),
      .DEPTH (HIT_DEPTH)
   ) u_hit_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (is_hit),
      .din   ({bin_q, bus.s_power}),
      .full  (fifo_full),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         n_q        <= '0;
         thresh_q   <= '0;
         bin_q      <= '0;
         occ_acc_q  <= '0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
         occ_count  <= '0;
         cfg_err    <= 1'b0;
         sync_err   <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         frame_done <= 1'b0;

         // A new error event in the same cycle as err_clr keeps the flag set.
         if (cfg_ev)       cfg_err  <= 1'b1;
         else if (err_clr) cfg_err  <= 1'b0;
         if (sync_ev)      sync_err <= 1'b1;
         else if (err_clr) sync_err <= 1'b0;
         if (ovf_ev)       ovf      <= 1'b1;
         else if (err_clr) ovf      <= 1'b0;

         case (state_q)
            StIdle: begin
               bin_q     <= '0;
               occ_acc_q <= '0;
               if (enable && cfg_ok) begin
                  state_q  <= StRun;
                  n_q      <= fft_size;
                  thresh_q <= thresh;
               end
            end
            StRun: begin
               if (frame_end) begin
                  frame_done <= 1'b1;
                  occ_count  <= occ_next;
                  frame_cnt  <= frame_cnt + IDX_W'(1);
                  occ_acc_q  <= '0;
                  bin_q      <= '0;
                  if (enable && cfg_ok) begin
                     n_q      <= fft_size;
                     thresh_q <= thresh;
                  end else begin
                     state_q <= StIdle;
                  end
               end else if (!enable) begin
                  // Abort the partial frame; queued hits keep draining.
                  state_q   <= StIdle;
                  bin_q     <= '0;
                  occ_acc_q <= '0;
               end else if (accept) begin
                  bin_q     <= bin_q + IDX_W'(1);
                  occ_acc_q <= occ_next;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_spectrum_detector.sv
// Scenario bench for spectrum_detector with a hit scoreboard fed at bin acceptance.
module tb_spectrum_detector;
   import spectrum_pkg::*;

   localparam int unsigned HIT_DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [15:0] fft_size;
   logic [15:0] thresh;
   logic        err_clr;
   logic        frame_done;
   logic [15:0] frame_cnt;
   logic [15:0] occ_count;
   logic        cfg_err, sync_err, ovf;

   spectrum_detector_if #(.DATA_W(16), .IDX_W(16)) bus ();

   spectrum_detector #(
      .DATA_W    (16),
      .IDX_W     (16),
      .HIT_DEPTH (HIT_DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .fft_size   (fft_size),
      .thresh     (thresh),
      .err_clr    (err_clr),
      .bus        (bus),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt),
      .occ_count  (occ_count),
      .cfg_err    (cfg_err),
      .sync_err   (sync_err),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   int          fd_cnt = 0;
   int          tb_idx;
   int          exp_frames = 0;
   logic [15:0] tb_thr;
   hit_t        exp_q[$];

   // Scoreboard: every hit handed out must match the oldest expected hit.
   always @(negedge clk) begin
      hit_t h;
      if (rst_n && frame_done) fd_cnt++;
      if (rst_n && bus.m_valid && bus.m_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL hit_pop: got idx=%0d power=%0d, required no hit", bus.m_idx, bus.m_power);
         end else begin
            h = exp_q.pop_front();
            if ({bus.m_idx, bus.m_power} !== {h.idx, h.power}) begin
               bad++;
               $display("FAIL hit_pop: got idx=%0d power=%0d, required idx=%0d power=%0d",
                        bus.m_idx, bus.m_power, h.idx, h.power);
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_err_clr();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   task automatic send_bin(input logic [15:0] pwr, input logic last);
      hit_t h;
      bus.s_valid = 1'b1;
      bus.s_power = pwr;
      bus.s_last  = last;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.s_ready) begin
            if (pwr > tb_thr && exp_q.size() < HIT_DEPTH) begin
               h.idx   = 16'(tb_idx);
               h.power = pwr;
               exp_q.push_back(h);
            end
            tb_idx++;
            @(posedge clk);
            #1;
            bus.s_valid = 1'b0;
            bus.s_last  = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      total++;
      bad++;
      $display("FAIL send_bin: s_ready=0 for 50 cycles, required 1");
      bus.s_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d hits still expected, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      enable = 1'b0; fft_size = 16'd16; thresh = 16'd100; err_clr = 1'b0;
      bus.s_valid = 1'b0; bus.s_power = '0; bus.s_last = 1'b0; bus.m_ready = 1'b1;
      tb_thr = 16'd100; tb_idx = 0;
      tick(3);
      total++;
      if ({bus.s_ready, bus.m_valid, frame_done, frame_cnt, occ_count, cfg_err, sync_err, ovf} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got %h, required 0",
                  {bus.s_ready, bus.m_valid, frame_done, frame_cnt, occ_count, cfg_err, sync_err, ovf});
      end
      rst_n = 1'b1;
      tick(2);
      total++;
      if (bus.s_ready !== 1'b0) begin
         bad++;
         $display("FAIL idle_not_ready: s_ready=%b required 0", bus.s_ready);
      end
   endtask

   task automatic test_basic_frame();
      int fd0 = fd_cnt;
      tb_thr = 16'd100; thresh = 16'd100; fft_size = 16'd16; tb_idx = 0;
      enable = 1'b1;
      for (int i = 0; i < 16; i++) send_bin(16'(i * 10), i == 15);
      tick(2);
      exp_frames++;
      wait_drain();
      total++;
      if (fd_cnt - fd0 != 1) begin
         bad++; $display("FAIL basic_frame_done: got %0d pulses, required 1", fd_cnt - fd0);
      end
      total++;
      if (occ_count !== 16'd5) begin
         bad++; $display("FAIL basic_occ: got %0d, required 5", occ_count);
      end
      total++;
      if (frame_cnt !== 16'(exp_frames)) begin
         bad++; $display("FAIL basic_frame_cnt: got %0d, required %0d", frame_cnt, exp_frames);
      end
      total++;
      if ({cfg_err, sync_err, ovf} !== 3'b000) begin
         bad++; $display("FAIL basic_flags: got %b, required 000", {cfg_err, sync_err, ovf});
      end
      enable = 1'b0;
      tick(2);
   endtask

   task automatic test_cfg_err();
      fft_size = 16'd24;
      enable = 1'b1;
      tick(3);
      total++;
      if (cfg_err !== 1'b1) begin
         bad++; $display("FAIL cfg_err_set: got %b, required 1", cfg_err);
      end
      total++;
      if (bus.s_ready !== 1'b0) begin
         bad++; $display("FAIL cfg_not_ready: s_ready=%b required 0", bus.s_ready);
      end
      fft_size = 16'd32;
      pulse_err_clr();
      total++;
      if (cfg_err !== 1'b0) begin
         bad++; $display("FAIL cfg_err_clr: got %b, required 0", cfg_err);
      end
      total++;
      if (bus.s_ready !== 1'b1) begin
         bad++; $display("FAIL cfg_run: s_ready=%b required 1", bus.s_ready);
      end
      enable = 1'b0;
      fft_size = 16'd16;
      tick(2);
   endtask

   task automatic test_overflow();
      int fd0 = fd_cnt;
      bus.m_ready = 1'b0;
      tb_thr = 16'd100; thresh = 16'd100; tb_idx = 0;
      enable = 1'b1;
      for (int i = 0; i < 16; i++) send_bin(16'hFFFF, i == 15);
      tick(2);
      exp_frames++;
      total++;
      if (ovf !== 1'b1) begin
         bad++; $display("FAIL ovf_set: got %b, required 1", ovf);
      end
      total++;
      if (occ_count !== 16'd16) begin
         bad++; $display("FAIL ovf_occ: got %0d, required 16", occ_count);
      end
      total++;
      if (fd_cnt - fd0 != 1) begin
         bad++; $display("FAIL ovf_frame_done: got %0d pulses, required 1", fd_cnt - fd0);
      end
      tick(3);
      total++;
      if ({bus.m_valid, bus.m_idx, bus.m_power} !== {1'b1, 16'd0, 16'hFFFF}) begin
         bad++;
         $display("FAIL ovf_stall_hold: got v=%b idx=%0d power=%h, required v=1 idx=0 power=ffff",
                  bus.m_valid, bus.m_idx, bus.m_power);
      end
      enable = 1'b0;
      bus.m_ready = 1'b1;
      wait_drain();
      tick();
      total++;
      if (bus.m_valid !== 1'b0) begin
         bad++; $display("FAIL ovf_empty: m_valid=%b required 0", bus.m_valid);
      end
      pulse_err_clr();
      total++;
      if (ovf !== 1'b0) begin
         bad++; $display("FAIL ovf_clr: got %b, required 0", ovf);
      end
   endtask

   task automatic test_sync_err();
      int fd0 = fd_cnt;
      tb_thr = 16'hFFFF; thresh = 16'hFFFF; tb_idx = 0;
      enable = 1'b1;
      for (int i = 0; i < 16; i++) begin
         send_bin(16'h1234, i == 7);
         if (i == 6) begin
            total++;
            if (sync_err !== 1'b0) begin
               bad++; $display("FAIL sync_early: got %b, required 0", sync_err);
            end
         end
         if (i == 7) begin
            total++;
            if (sync_err !== 1'b1) begin
               bad++; $display("FAIL sync_set: got %b, required 1", sync_err);
            end
         end
      end
      tick(2);
      exp_frames++;
      total++;
      if (fd_cnt - fd0 != 1) begin
         bad++; $display("FAIL sync_frame_done: got %0d pulses, required 1", fd_cnt - fd0);
      end
      total++;
      if (occ_count !== 16'd0) begin
         bad++; $display("FAIL sync_occ: got %0d, required 0", occ_count);
      end
      enable = 1'b0;
      pulse_err_clr();
      total++;
      if (sync_err !== 1'b0) begin
         bad++; $display("FAIL sync_clr: got %b, required 0", sync_err);
      end
   endtask

   task automatic test_abort();
      int fd0 = fd_cnt;
      tb_thr = 16'd100; thresh = 16'd100; tb_idx = 0;
      enable = 1'b1;
      for (int i = 0; i < 6; i++) send_bin(16'd200, 1'b0);
      enable = 1'b0;
      tick(3);
      wait_drain();
      total++;
      if (fd_cnt != fd0 || occ_count !== 16'd0 || frame_cnt !== 16'(exp_frames)) begin
         bad++;
         $display("FAIL abort_hold: got fd=%0d occ=%0d cnt=%0d, required fd=0 occ=0 cnt=%0d",
                  fd_cnt - fd0, occ_count, frame_cnt, exp_frames);
      end
      tb_idx = 0;
      enable = 1'b1;
      for (int i = 0; i < 16; i++) send_bin((i == 0 || i == 3) ? 16'd500 : 16'd20, i == 15);
      tick(2);
      exp_frames++;
      wait_drain();
      total++;
      if (occ_count !== 16'd2 || frame_cnt !== 16'(exp_frames)) begin
         bad++;
         $display("FAIL abort_restart: got occ=%0d cnt=%0d, required occ=2 cnt=%0d",
                  occ_count, frame_cnt, exp_frames);
      end
      enable = 1'b0;
      tick(2);
   endtask

   task automatic test_thresh_change();
      int fd0 = fd_cnt;
      tb_thr = 16'd100; thresh = 16'd100; tb_idx = 0;
      enable = 1'b1;
      for (int i = 0; i < 16; i++) begin
         send_bin(16'd80, i == 15);
         if (i == 0) thresh = 16'd50;
      end
      exp_frames++;
      total++;
      if (occ_count !== 16'd0) begin
         bad++; $display("FAIL thr_old_frame: occ=%0d, required 0", occ_count);
      end
      tb_thr = 16'd50; tb_idx = 0;
      for (int i = 0; i < 16; i++) send_bin((i % 2 == 1) ? 16'd80 : 16'd40, i == 15);
      tick(2);
      exp_frames++;
      wait_drain();
      total++;
      if (occ_count !== 16'd8 || frame_cnt !== 16'(exp_frames) || fd_cnt - fd0 != 2) begin
         bad++;
         $display("FAIL thr_new_frame: got occ=%0d cnt=%0d fd=%0d, required occ=8 cnt=%0d fd=2",
                  occ_count, frame_cnt, fd_cnt - fd0, exp_frames);
      end
      enable = 1'b0;
      tick(2);
   endtask

   task automatic test_reset_mid_frame();
      bus.m_ready = 1'b0;
      tb_thr = 16'd100; thresh = 16'd100; tb_idx = 0;
      enable = 1'b1;
      for (int i = 0; i < 4; i++) send_bin(16'd300, 1'b0);
      tick();
      total++;
      if (bus.m_valid !== 1'b1) begin
         bad++; $display("FAIL rst_pre_valid: m_valid=%b required 1", bus.m_valid);
      end
      rst_n = 1'b0;
      enable = 1'b0;
      #2;
      exp_q.delete();
      total++;
      if ({bus.m_valid, bus.s_ready, frame_cnt, occ_count} !== '0) begin
         bad++;
         $display("FAIL rst_mid: got v=%b rdy=%b cnt=%0d occ=%0d, required all 0",
                  bus.m_valid, bus.s_ready, frame_cnt, occ_count);
      end
      tick();
      rst_n = 1'b1;
      bus.m_ready = 1'b1;
      tick(2);
      total++;
      if (bus.m_valid !== 1'b0) begin
         bad++; $display("FAIL rst_fifo_cleared: m_valid=%b required 0", bus.m_valid);
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_cfg_err();
      test_overflow();
      test_sync_err();
      test_abort();
      test_thresh_change();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
